uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL provide port: clk  input  1  system clock; all state changes on rising edge.
REQ-002 The block SHALL provide port: rst  input  1  reset, synchronous, active-high.
REQ-003 The block SHALL provide port: baud_tick  input  1  one-clk pulse marking each bit-period boundary.
REQ-004 The block SHALL provide port: p_sel  input  1  parity select; 1 = parity bit is XOR of data bits, 0 = its inverse.
REQ-005 The block SHALL provide port: tx_data  input  8  byte to transmit.
REQ-006 The block SHALL provide port: tx_valid  input  1  byte offered on tx_data.
REQ-007 The block SHALL provide port: tx_ready  output  1  holding register empty; byte accepted when tx_valid and tx_ready are both 1 at a clk edge.
REQ-008 The block SHALL provide port: tx  output  1  serial line, idle high.
REQ-009 The block SHALL provide port: busy  output  1  frame in progress (state not IDLE).
REQ-010 The block SHALL provide port: tx_done  output  1  one-clk pulse at end of stop bit.

Function
REQ-011 Frame SHALL be: start (0), 8 data bits LSB first, 1 parity bit, stop (1); 11 bit periods total.
REQ-012 A one-entry holding register (byte plus captured p_sel) SHALL decouple the handshake from the serializer; tx_ready SHALL be registered and equal to "holding register empty".
REQ-013 On an accept edge, tx_data and p_sel SHALL be captured into the holding register and tx_ready SHALL be 0 from the next cycle.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all transitions SHALL occur only on edges where baud_tick=1, except reset.
REQ-015 IDLE: tx=1; on baud_tick with holding register full -> move holding register into shift register, clear holding register (tx_ready=1 next cycle), compute parity, go START, tx=0.
REQ-016 START: on baud_tick -> DATA, tx=shift[0], bit index=0.
REQ-017 DATA: on baud_tick, index<7 -> shift right, index+1, tx=next bit; index==7 -> PARITY, tx=parity bit.
REQ-018 PARITY: on baud_tick -> STOP, tx=1.
REQ-019 STOP: on baud_tick -> tx_done=1 for that one cycle; if holding register full, load it and go START (tx=0) with no idle period; else go IDLE, tx=1.
REQ-020 Parity SHALL use the p_sel captured with that byte; p_sel changes after acceptance SHALL NOT affect the frame.
REQ-021 tx_data changes while tx_ready=0 or tx_valid=0 SHALL be ignored.
REQ-022 tx SHALL be driven from a register (glitch-free); each bit SHALL be held for exactly one baud_tick interval.
REQ-023 A new byte SHALL be acceptable while a frame is in flight (tx_ready=1 once holding register drains), allowing back-to-back frames.
REQ-024 baud_tick and tx_valid asserted on the same edge in IDLE with holding register empty SHALL only accept the byte; transmission starts on the following baud_tick.

Reset
REQ-025 While rst=1 at a clk edge: state=IDLE, tx=1, tx_ready=1, busy=0, tx_done=0, holding register and shift register cleared, bit index=0.
REQ-026 Reset mid-frame SHALL abort the frame; tx=1 from the next cycle; any held byte SHALL be discarded; tx_valid during rst SHALL NOT be accepted.

Verification
REQ-027 tx_data=0xA5, p_sel=1, one accept -> tx sequence per baud period 0,1,0,1,0,0,1,0,1,0(parity),1(stop); tx_done one pulse; busy 0 after.
REQ-028 tx_data=0xA5, p_sel=0 -> identical frame except parity bit=1; tx_data=0x01, p_sel=1 -> parity bit=1.
REQ-029 Two bytes 0x3C then 0xFF offered back-to-back -> second accepted during first frame; second start bit immediately follows first stop bit; tx_ready deasserted while holding register full.
REQ-030 p_sel toggled after acceptance of 0x0F with p_sel=1 -> parity bit=0 (captured value used).
REQ-031 rst asserted during DATA bit 4 -> tx=1, busy=0, tx_ready=1 next cycle; no tx_done; next accepted byte sends a complete, correct frame.
REQ-032 baud_tick held low for 50 clks mid-frame -> tx holds current bit level, state unchanged.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, one parity bit, one stop bit.
// A one-entry holding register lets the next byte be offered while a frame is on the line.
module uart_tx (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic       p_sel,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy,
   output logic       tx_done
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t     state_q;
   logic [7:0] hold_data_q;
   logic       hold_psel_q;
   logic       hold_empty_q;
   logic [7:0] shift_q;
   logic [2:0] bit_idx_q;
   logic       parity_q;
   logic       tx_q;
   logic       busy_q;
   logic       done_q;

   logic       accept_d;
   logic       start_d;
   logic       parity_d;

   assign accept_d = tx_valid & hold_empty_q;
   // A frame may begin from IDLE or straight out of STOP so back-to-back frames have no gap.
   assign start_d  = baud_tick & ~hold_empty_q & ((state_q == IDLE) | (state_q == STOP));
   assign parity_d = hold_psel_q ? (^hold_data_q) : ~(^hold_data_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         hold_data_q  <= 8'h00;
         hold_psel_q  <= 1'b0;
         hold_empty_q <= 1'b1;
         shift_q      <= 8'h00;
         bit_idx_q    <= 3'd0;
         parity_q     <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= baud_tick & (state_q == STOP);

         if (accept_d) begin
            hold_data_q  <= tx_data;
            hold_psel_q  <= p_sel;
            hold_empty_q <= 1'b0;
         end

         if (start_d) begin
            shift_q      <= hold_data_q;
            parity_q     <= parity_d;
            hold_empty_q <= 1'b1;
            bit_idx_q    <= 3'd0;
            state_q      <= START;
            tx_q         <= 1'b0;
            busy_q       <= 1'b1;
         end else if (baud_tick) begin
            case (state_q)
               IDLE: begin
                  tx_q   <= 1'b1;
                  busy_q <= 1'b0;
               end
               START: begin
                  state_q   <= DATA;
                  bit_idx_q <= 3'd0;
                  tx_q      <= shift_q[0];
               end
               DATA: begin
                  if (bit_idx_q == 3'd7) begin
                     state_q <= PARITY;
                     tx_q    <= parity_q;
                  end else begin
                     shift_q   <= {1'b0, shift_q[7:1]};
                     bit_idx_q <= bit_idx_q + 3'd1;
                     tx_q      <= shift_q[1];
                  end
               end
               PARITY: begin
                  state_q <= STOP;
                  tx_q    <= 1'b1;
               end
               STOP: begin
                  state_q <= IDLE;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign tx_ready = hold_empty_q;
   assign tx       = tx_q;
   assign busy     = busy_q;
   assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line receiver model decodes every frame on tx at each baud tick
// and compares it against the bytes the bench accepted, with parity derived from bit counts.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud_tick;
   logic       p_sel;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       par;
   } frame_t;

   frame_t exp_q[$];

   logic        tick_en = 1'b1;
   int          tick_idx = 0;
   int          rx_cnt = 0;
   int          last_stop_tick = -100;
   int          last_gap = 0;
   int          frames_rx = 0;
   int          done_cnt = 0;
   logic [10:0] rx_bits;

   always #5 clk = ~clk;

   uart_tx dut (
      .clk       (clk),
      .rst       (rst),
      .baud_tick (baud_tick),
      .p_sel     (p_sel),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx        (tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   // Parity bit as seen on the wire: odd count of ones gives 1 when p_sel=1.
   function automatic logic exp_par(input logic [7:0] b, input logic ps);
      int ones;
      ones = $countones(b);
      return ps ? ones[0] : ~ones[0];
   endfunction

   task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Baud tick generator: one pulse every 4 clocks while enabled.
   initial begin
      int cnt;
      cnt = 0;
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         cnt++;
         baud_tick = tick_en && (cnt % 4 == 0);
      end
   end

   // Line receiver: samples tx once per bit period just after each tick edge.
   initial begin
      frame_t     e;
      logic [7:0] got;
      forever begin
         @(posedge clk);
         if (rst === 1'b1) begin
            rx_cnt = 0;
         end else if (baud_tick === 1'b1) begin
            #1;
            tick_idx++;
            if (rx_cnt == 0) begin
               if (tx === 1'b0) begin
                  rx_cnt   = 1;
                  last_gap = tick_idx - last_stop_tick;
               end
            end else begin
               rx_bits[rx_cnt] = tx;
               rx_cnt++;
               if (rx_cnt == 11) begin
                  got = rx_bits[8:1];
                  checks++;
                  assert (exp_q.size() > 0)
                  else begin
                     errors++;
                     $error("FAIL unexpected_frame observed=%02h expected=none", got);
                  end
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check1("frame_data", got, e.data);
                     check1("frame_parity", {7'd0, rx_bits[9]}, {7'd0, e.par});
                     check1("frame_stop", {7'd0, rx_bits[10]}, 8'd1);
                     $display("frame data=%02h parity=%0d stop=%0d", got, rx_bits[9], rx_bits[10]);
                  end
                  frames_rx++;
                  rx_cnt = 0;
                  last_stop_tick = tick_idx;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (tx_done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic send(input logic [7:0] b, input logic ps);
      int n;
      n = 0;
      @(negedge clk);
      #1;
      tx_data  = b;
      p_sel    = ps;
      tx_valid = 1'b1;
      while (tx_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      assert (n < 5000)
      else begin
         errors++;
         $error("FAIL send_timeout observed=%0d expected=<5000", n);
      end
      exp_q.push_back('{b, exp_par(b, ps)});
      @(posedge clk);
      #1;
      check1("ready_after_accept", {7'd0, tx_ready}, 8'd0);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      p_sel    = 1'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(busy === 1'b0 && tx_ready === 1'b1 && rx_cnt == 0 && exp_q.size() == 0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (n < 3000)
      else begin
         errors++;
         $error("FAIL idle_timeout observed=%0d expected=<3000", n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_rx(input int target);
      int n;
      n = 0;
      while (rx_cnt != target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert (n < 3000)
      else begin
         errors++;
         $error("FAIL rx_wait_timeout observed=%0d expected=%0d", rx_cnt, target);
      end
   endtask

   initial begin
      int   d0;
      int   f0;
      int   n;
      logic tx_s;
      logic stable;

      rst      = 1'b1;
      tx_valid = 1'b0;
      p_sel    = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check1("reset_tx", {7'd0, tx}, 8'd1);
      check1("reset_ready", {7'd0, tx_ready}, 8'd1);
      check1("reset_busy", {7'd0, busy}, 8'd0);
      check1("reset_done", {7'd0, tx_done}, 8'd0);
      rst = 1'b0;

      // Single frame 0xA5 with XOR parity.
      send(8'hA5, 1'b1);
      wait_idle();
      check1("a5_busy_after", {7'd0, busy}, 8'd0);
      check1("a5_done_count", 8'(done_cnt), 8'd1);

      // Inverted parity, then a single set bit.
      send(8'hA5, 1'b0);
      send(8'h01, 1'b1);
      wait_idle();

      // Back-to-back: second byte accepted while the first is on the line.
      f0 = frames_rx;
      send(8'h3C, 1'b1);
      send(8'hFF, 1'b0);
      check1("b2b_busy_at_accept", {7'd0, busy}, 8'd1);
      check1("b2b_first_in_flight", 8'(frames_rx - f0), 8'd0);
      wait_idle();
      check1("b2b_gap_ticks", 8'(last_gap), 8'd1);

      // p_sel changes after acceptance must not alter the parity.
      send(8'h0F, 1'b1);
      p_sel = 1'b0;
      repeat (6) begin
         @(negedge clk);
         p_sel = ~p_sel;
      end
      wait_idle();

      // Accept coinciding with a baud tick in IDLE only fills the holding register.
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (baud_tick !== 1'b1 && n < 100);
      tx_data  = 8'h5A;
      p_sel    = 1'b1;
      tx_valid = 1'b1;
      exp_q.push_back('{8'h5A, exp_par(8'h5A, 1'b1)});
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      check1("same_edge_tx", {7'd0, tx}, 8'd1);
      check1("same_edge_busy", {7'd0, busy}, 8'd0);
      check1("same_edge_ready", {7'd0, tx_ready}, 8'd0);
      wait_idle();

      // Baud stall mid-frame: line and state hold.
      send(8'hC3, 1'b1);
      wait_rx(3);
      tick_en = 1'b0;
      repeat (3) @(negedge clk);
      tx_s   = tx;
      stable = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (tx !== tx_s || busy !== 1'b1) stable = 1'b0;
      end
      check1("stall_hold", {7'd0, stable}, 8'd1);
      tick_en = 1'b1;
      wait_idle();

      // Reset while data bit 4 is on the line.
      d0 = done_cnt;
      send(8'h96, 1'b0);
      wait_rx(6);
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h77;
      @(negedge clk);
      rst      = 1'b0;
      tx_valid = 1'b0;
      exp_q.delete();
      check1("abort_tx", {7'd0, tx}, 8'd1);
      check1("abort_busy", {7'd0, busy}, 8'd0);
      check1("abort_ready", {7'd0, tx_ready}, 8'd1);
      check1("abort_done", {7'd0, tx_done}, 8'd0);
      repeat (60) @(negedge clk);
      check1("abort_no_done", 8'(done_cnt - d0), 8'd0);
      check1("abort_line_idle", 8'(rx_cnt), 8'd0);
      check1("abort_still_idle", {7'd0, busy}, 8'd0);
      send(8'h96, 1'b0);
      wait_idle();

      // Random bytes and parity selections with random gaps.
      for (int i = 0; i < 10; i++) begin
         send(8'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_idle();

      check1("done_vs_frames", 8'(done_cnt), 8'(frames_rx));
      check1("queue_drained", 8'(exp_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
